// File: rtl/dm_responder.sv
// dm_responder: single-request memory responder for a debug-module bus.
//
// A request is accepted in IDLE. The state then waits WAIT_CYCLES cycles,
// performs the access on the edge entering RESP, and holds the response
// until the initiator takes it. Errored requests take the same latency
// and have no memory effect.
//
// Ports:
//   clk, rst_n    clock; asynchronous active-low reset
//   req_valid     request present
//   req_ready     responder can accept (high only in IDLE)
//   req_read      load request
//   req_write     store request
//   req_size      0 byte, 1 half, 2 word, 3 double
//   req_addr      byte address
//   req_wdata     store data, right-aligned
//   rsp_valid     response present
//   rsp_ready     initiator accepts response
//   rsp_rdata     load data, right-aligned, zero-extended
//   rsp_err       request rejected, no memory effect
module dm_responder #(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_read,
    input  logic            req_write,
    input  logic [1:0]      req_size,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int unsigned NB = XLEN / 8;
    // Only meaningful when WAIT_CYCLES > 0; the WAIT state is unreachable otherwise.
    localparam logic [CW-1:0]   CNT_LAST = CW'(WAIT_CYCLES - 1);
    localparam logic [XLEN-4:0] DEPTH_W  = (XLEN-3)'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            lat_read;
    logic            lat_write;
    logic [1:0]      lat_size;
    logic [XLEN-1:0] lat_addr;
    logic [XLEN-1:0] lat_wdata;

    logic [XLEN-1:0] mem [DEPTH];

    // Operand view: with WAIT_CYCLES == 0 the access happens on the accept
    // edge itself, so the live request must be used instead of the latch.
    logic            cur_read;
    logic            cur_write;
    logic [1:0]      cur_size;
    logic [XLEN-1:0] cur_addr;
    logic [XLEN-1:0] cur_wdata;

    logic [2:0]      off;
    logic [AW-1:0]   idx;
    logic [2:0]      align_mask;
    logic            cur_err;
    logic            enter_resp;
    logic            do_store;
    logic [NB-1:0]   wr_en;
    logic [XLEN-1:0] wr_shift;
    logic [XLEN-1:0] rd_shift;
    logic [XLEN-1:0] rd_data;
    logic [XLEN-1:0] rsp_data_next;

    always_comb begin
        if (state == StIdle) begin
            cur_read  = req_read;
            cur_write = req_write;
            cur_size  = req_size;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
        end else begin
            cur_read  = lat_read;
            cur_write = lat_write;
            cur_size  = lat_size;
            cur_addr  = lat_addr;
            cur_wdata = lat_wdata;
        end
    end

    assign off = cur_addr[2:0];
    assign idx = cur_addr[AW+2:3];

    always_comb begin
        align_mask = 3'b000;
        unique case (cur_size)
            2'd0: align_mask = 3'b000;
            2'd1: align_mask = 3'b001;
            2'd2: align_mask = 3'b011;
            2'd3: align_mask = 3'b111;
            default: align_mask = 3'b111;
        endcase
    end

    assign cur_err = (cur_read == cur_write)
                   || ((off & align_mask) != 3'b000)
                   || (cur_addr[XLEN-1:3] >= DEPTH_W);

    assign enter_resp = ((state == StIdle) && req_valid && (WAIT_CYCLES == 0))
                      || ((state == StWait) && (cnt == CNT_LAST));
    assign do_store = enter_resp && cur_write && !cur_err;

    // Byte lanes off .. off+2^size-1, fed from the low bytes of the store data.
    always_comb begin
        wr_en = '0;
        for (int b = 0; b < NB; b++) begin
            wr_en[b] = (b >= int'(off)) && (b < int'(off) + (1 << cur_size));
        end
    end

    assign wr_shift = cur_wdata << {off, 3'b000};
    assign rd_shift = mem[idx] >> {off, 3'b000};

    always_comb begin
        rd_data = '0;
        for (int b = 0; b < NB; b++) begin
            if (b < (1 << cur_size)) begin
                rd_data[8*b +: 8] = rd_shift[8*b +: 8];
            end
        end
    end

    assign rsp_data_next = (cur_err || cur_write) ? '0 : rd_data;

    // Storage has no reset: contents are undefined until written.
    always_ff @(posedge clk) begin
        if (do_store) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_en[b]) begin
                    mem[idx][8*b +: 8] <= wr_shift[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            cnt       <= '0;
            lat_read  <= 1'b0;
            lat_write <= 1'b0;
            lat_size  <= 2'd0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (req_valid) begin
                        lat_read  <= req_read;
                        lat_write <= req_write;
                        lat_size  <= req_size;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        req_ready <= 1'b0;
                        cnt       <= '0;
                        state     <= enter_resp ? StResp : StWait;
                    end
                end
                StWait: begin
                    if (enter_resp) begin
                        state <= StResp;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        state     <= StIdle;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    state     <= StIdle;
                    req_ready <= 1'b1;
                end
            endcase
            if (enter_resp) begin
                rsp_valid <= 1'b1;
                rsp_err   <= cur_err;
                rsp_rdata <= rsp_data_next;
            end
        end
    end

endmodule
